// File: rtl/div_sqrt_round_pack.sv
// FP32 divide/sqrt output stage: normalize, round, detect overflow/underflow, pack.
// 2-stage valid/ready pipeline; optional macro DIV_SQRT_SUBNORMAL_EN enables gradual underflow.
module div_sqrt_round_pack #(
  parameter int QWIDTH   = 26,
  parameter int RWIDTH   = 27,
  parameter int EXPWIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [QWIDTH-1:0]   in_quotient,
  input  logic [RWIDTH-1:0]   in_remainder,
  input  logic                in_sign,
  input  logic [EXPWIDTH-1:0] in_exp,
  input  logic [1:0]          in_class,
  input  logic [1:0]          in_rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic [2:0]          out_flags,
  output logic                overrun
);

  localparam logic [EXPWIDTH-1:0] EXP_ONE = EXPWIDTH'(1);

  logic                s1_vld_q, s2_vld_q, overrun_q, s2_adv;
  logic                s1_sign_q, s1_grd_q, s1_stk_q, s1_hid_q, s1_tiny_q;
  logic [1:0]          s1_cls_q, s1_rm_q;
  logic [EXPWIDTH-1:0] s1_exp_q;
  logic [22:0]         s1_mant_q;
  logic [31:0]         out_result_q;
  logic [2:0]          out_flags_q;

  logic [EXPWIDTH-1:0] exp_d;
  logic [22:0]         mant_d;
  logic                grd_d, stk_d, hid_d, tiny_d;

`ifdef DIV_SQRT_SUBNORMAL_EN
  logic [EXPWIDTH-1:0] sh_amt;
  logic [4:0]          sh;
  logic [49:0]         wide;
`endif

  assign s2_adv     = ~s2_vld_q | out_ready;
  assign in_ready   = ~s1_vld_q | s2_adv;
  assign out_valid  = s2_vld_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign overrun    = overrun_q;

  // Stage 1: the core guarantees the top two quotient bits are not both zero.
  always_comb begin
    exp_d  = in_exp;
    mant_d = in_quotient[QWIDTH-2:QWIDTH-24];
    grd_d  = in_quotient[QWIDTH-25];
    stk_d  = in_quotient[0] | (|in_remainder);
    hid_d  = 1'b1;
    if (!in_quotient[QWIDTH-1]) begin
      mant_d = in_quotient[QWIDTH-3:QWIDTH-25];
      grd_d  = in_quotient[0];
      stk_d  = |in_remainder;
      exp_d  = in_exp - EXP_ONE;
    end
    tiny_d = exp_d[EXPWIDTH-1] | (exp_d == '0);
`ifdef DIV_SQRT_SUBNORMAL_EN
    sh_amt = EXP_ONE - exp_d;
    sh     = (sh_amt > EXPWIDTH'(26)) ? 5'd26 : sh_amt[4:0];
    wide   = {1'b1, mant_d, grd_d, 25'b0} >> sh;
    if (tiny_d) begin
      hid_d  = wide[49];
      mant_d = wide[48:26];
      grd_d  = wide[25];
      stk_d  = stk_d | (|wide[24:0]);
      exp_d  = '0;
    end
`endif
  end

  logic              inexact, inc, bump, ovf, inf_sel;
  logic [24:0]       sum;
  logic [EXPWIDTH:0] exp_r;
  logic [22:0]       mant_r;
  logic [31:0]       res_d;
  logic [2:0]        flags_d;

  always_comb begin
    inexact = s1_grd_q | s1_stk_q;
    unique case (s1_rm_q)
      2'b00:   inc = s1_grd_q & (s1_stk_q | s1_mant_q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = s1_sign_q & inexact;
      default: inc = ~s1_sign_q & inexact;
    endcase
    sum     = {1'b0, s1_hid_q, s1_mant_q} + {24'b0, inc};
    // A subnormal carrying into the hidden position becomes the smallest normal.
    bump    = sum[24] | (~s1_hid_q & sum[23]);
    exp_r   = {s1_exp_q[EXPWIDTH-1], s1_exp_q} + {{EXPWIDTH{1'b0}}, bump};
    mant_r  = sum[24] ? 23'b0 : sum[22:0];
    ovf     = ~exp_r[EXPWIDTH] & (exp_r[EXPWIDTH-1:0] >= EXPWIDTH'(255));
    inf_sel = (s1_rm_q == 2'b00) | ((s1_rm_q == 2'b10) & s1_sign_q)
            | ((s1_rm_q == 2'b11) & ~s1_sign_q);
    res_d   = {s1_sign_q, exp_r[7:0], mant_r};
    flags_d = {2'b00, inexact};
`ifdef DIV_SQRT_SUBNORMAL_EN
    flags_d[1] = s1_tiny_q & inexact;
`else
    if (s1_tiny_q) begin
      res_d   = {s1_sign_q, 31'b0};
      flags_d = 3'b011;
    end
`endif
    if (ovf) begin
      res_d   = inf_sel ? {s1_sign_q, 8'hFF, 23'b0} : {s1_sign_q, 8'hFE, 23'h7FFFFF};
      flags_d = 3'b101;
    end
    unique case (s1_cls_q)
      2'b01:   begin res_d = {s1_sign_q, 31'b0};         flags_d = 3'b000; end
      2'b10:   begin res_d = {s1_sign_q, 8'hFF, 23'b0};  flags_d = 3'b000; end
      2'b11:   begin res_d = 32'h7FC00000;               flags_d = 3'b000; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      overrun_q    <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_cls_q     <= 2'b00;
      s1_rm_q      <= 2'b00;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_grd_q     <= 1'b0;
      s1_stk_q     <= 1'b0;
      s1_hid_q     <= 1'b1;
      s1_tiny_q    <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      overrun_q <= overrun_q | (in_valid & ~in_ready);
      if (in_ready) begin
        s1_vld_q <= in_valid;
        if (in_valid) begin
          s1_sign_q <= in_sign;
          s1_cls_q  <= in_class;
          s1_rm_q   <= in_rm;
          s1_exp_q  <= exp_d;
          s1_mant_q <= mant_d;
          s1_grd_q  <= grd_d;
          s1_stk_q  <= stk_d;
          s1_hid_q  <= hid_d;
          s1_tiny_q <= tiny_d;
        end
      end
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_result_q <= res_d;
          out_flags_q  <= flags_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_sqrt_round_pack.sv
// Scoreboard bench for div_sqrt_round_pack: directed vectors, decoupled monitor.
module tb_div_sqrt_round_pack;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sign, out_valid, out_ready, overrun;
  logic [25:0] in_quotient;
  logic [26:0] in_remainder;
  logic [9:0]  in_exp;
  logic [1:0]  in_class, in_rm;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  logic [34:0] sb[$];
  int total = 0;
  int bad = 0;

  div_sqrt_round_pack dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_quotient(in_quotient), .in_remainder(in_remainder),
    .in_sign(in_sign), .in_exp(in_exp), .in_class(in_class), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [34:0] got, input logic [34:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Drives one in_valid cycle; caller sits just after a rising edge.
  task automatic send(input logic [25:0] q, input logic [26:0] r, input logic [9:0] e,
                      input logic s, input logic [1:0] c, input logic [1:0] m,
                      input logic [31:0] xr, input logic [2:0] xf, input bit push);
    in_valid = 1'b1; in_quotient = q; in_remainder = r; in_exp = e;
    in_sign = s; in_class = c; in_rm = m;
    if (push) sb.push_back({xf, xr});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 35'(sb.size()), 35'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_quotient = '0;
    in_remainder = '0; in_exp = '0; in_sign = 1'b0; in_class = 2'b00; in_rm = 2'b00;

    fork
      forever begin
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", {out_flags, out_result}, 35'h7_FFFF_FFFF ^ {out_flags, out_result});
          end else begin
            check("result", {out_flags, out_result}, sb.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 35'(out_valid), 35'd0);
    check("rst_out_result", 35'(out_result), 35'd0);
    check("rst_out_flags", 35'(out_flags), 35'd0);
    check("rst_overrun", 35'(overrun), 35'd0);
    check("rst_in_ready", 35'(in_ready), 35'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    send(26'h3000000, 27'd0, 10'd127, 1'b0, 2'b00, 2'b00, 32'h3FC00000, 3'b000, 1);
    check("latency_1cyc", 35'(out_valid), 35'd0);
    @(posedge clk); #1;
    check("latency_2cyc", 35'(out_valid), 35'd1);
    drain();

    send(26'h1000000, 27'd0, 10'd128, 1'b0, 2'b00, 2'b00, 32'h3F800000, 3'b000, 1);
    send(26'h2000002, 27'd0, 10'd127, 1'b0, 2'b00, 2'b00, 32'h3F800000, 3'b001, 1);
    send(26'h2000002, 27'd1, 10'd127, 1'b0, 2'b00, 2'b00, 32'h3F800001, 3'b001, 1);
    send(26'h2000006, 27'd0, 10'd127, 1'b0, 2'b00, 2'b00, 32'h3F800002, 3'b001, 1);
    send(26'h2000002, 27'd1, 10'd127, 1'b0, 2'b00, 2'b10, 32'h3F800000, 3'b001, 1);
    send(26'h3FFFFFF, 27'd0, 10'd254, 1'b0, 2'b00, 2'b00, 32'h7F800000, 3'b101, 1);
    send(26'h3FFFFFF, 27'd0, 10'd254, 1'b0, 2'b00, 2'b01, 32'h7F7FFFFF, 3'b001, 1);
    send(26'h3FFFFFF, 27'd0, 10'd255, 1'b0, 2'b00, 2'b01, 32'h7F7FFFFF, 3'b101, 1);
    send(26'h3FFFFFF, 27'd0, 10'd254, 1'b1, 2'b00, 2'b10, 32'hFF800000, 3'b101, 1);
    send(26'h3FFFFFF, 27'd0, 10'd254, 1'b1, 2'b00, 2'b11, 32'hFF7FFFFF, 3'b001, 1);
    send(26'h3FFFFFF, 27'd0, 10'd127, 1'b1, 2'b01, 2'b00, 32'h80000000, 3'b000, 1);
    send(26'h3FFFFFF, 27'd5, 10'd300, 1'b0, 2'b10, 2'b01, 32'h7F800000, 3'b000, 1);
    send(26'h1234567, 27'd0, 10'd3,   1'b1, 2'b11, 2'b00, 32'h7FC00000, 3'b000, 1);
`ifdef DIV_SQRT_SUBNORMAL_EN
    send(26'h2000000, 27'd0, 10'd0,   1'b0, 2'b00, 2'b00, 32'h00400000, 3'b000, 1);
    send(26'h2000000, 27'd0, -10'sd5, 1'b1, 2'b00, 2'b00, 32'h80020000, 3'b000, 1);
`else
    send(26'h2000000, 27'd0, 10'd0,   1'b0, 2'b00, 2'b00, 32'h00000000, 3'b011, 1);
    send(26'h2000000, 27'd0, -10'sd5, 1'b1, 2'b00, 2'b11, 32'h80000000, 3'b011, 1);
`endif
    drain();

    out_ready = 1'b0;
    send(26'h3000000, 27'd0, 10'd127, 1'b0, 2'b00, 2'b00, 32'h3FC00000, 3'b000, 1);
    send(26'h1000000, 27'd0, 10'd128, 1'b0, 2'b00, 2'b00, 32'h3F800000, 3'b000, 1);
    check("in_ready_full", 35'(in_ready), 35'd0);
    check("overrun_before", 35'(overrun), 35'd0);
    send(26'h2000002, 27'd1, 10'd127, 1'b0, 2'b00, 2'b00, 32'h3F800001, 3'b001, 0);
    check("overrun_set", 35'(overrun), 35'd1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_hold", {out_flags, out_result}, {3'b000, 32'h3FC00000});
    out_ready = 1'b1;
    drain();

    send(26'h3000000, 27'd0, 10'd127, 1'b0, 2'b00, 2'b00, 32'h3FC00000, 3'b000, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 35'(out_valid), 35'd0);
    check("midrst_overrun", 35'(overrun), 35'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_output", 35'(out_valid), 35'd0);
    check("final_queue", 35'(sb.size()), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
